// File: rtl/arb_req_frontend.sv
// arb_req_frontend: four per-requester FIFOs feeding a round-robin arbiter, popping on a one-hot grant.
module arb_req_frontend #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_ready,
  output logic [3:0]      req,
  input  logic [3:0]      gnt,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_id,
  output logic            err_multi_gnt,
  input  logic            err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [DW-1:0] mem [4][DEPTH];
  logic [AW-1:0] wptr [4];
  logic [AW-1:0] rptr [4];
  logic [AW:0]   cnt  [4];
  logic [3:0]    push, pop;
  logic          multi, one_hot;
  logic [1:0]    sel;
  assign multi   = (gnt & (gnt - 4'd1)) != 4'd0;
  assign one_hot = (gnt != 4'd0) && !multi;
  assign sel     = {gnt[2] | gnt[3], gnt[1] | gnt[3]};
  for (genvar g = 0; g < 4; g++) begin : g_q
    assign in_ready[g] = cnt[g] < FULL;
    assign req[g]      = cnt[g] != '0;
    assign push[g]     = in_valid[g] & in_ready[g];
    assign pop[g]      = one_hot & gnt[g] & req[g];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (push[i]) mem[i][wptr[i]] <= in_data[i*DW +: DW];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_id        <= '0;
      err_multi_gnt <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + AW'(1);
        if (pop[i])  rptr[i] <= rptr[i] + AW'(1);
        cnt[i] <= cnt[i] + {{AW{1'b0}}, push[i]} - {{AW{1'b0}}, pop[i]};
      end
      out_valid <= |pop;
      if (|pop) begin
        out_data <= mem[sel][rptr[sel]];
        out_id   <= sel;
      end
      err_multi_gnt <= multi | (err_multi_gnt & ~err_clr);
    end
  end
endmodule

// File: tb/tb_arb_req_frontend.sv
// tb_arb_req_frontend: directed-step bench for arb_req_frontend with DW=8, DEPTH=4.
module tb_arb_req_frontend;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_ready, req, gnt = '0;
  logic        out_valid, err_multi_gnt, err_clr = 1'b0;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  int checks = 0;
  int errors = 0;

  arb_req_frontend #(.DW(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .req(req), .gnt(gnt), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .err_multi_gnt(err_multi_gnt),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input logic [1:0] id);
    chk({tag, "_ov"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_id"}, 32'(out_id), 32'(id));
  endtask

  initial begin
    #2;
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_rdy", 32'(in_ready), 32'hf);
    chk("rst_ov", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_id", 32'(out_id), 32'h0);
    chk("rst_err", 32'(err_multi_gnt), 32'h0);
    tick();
    rst_n = 1'b1;
    // single entry through queue 0
    in_valid = 4'b0001; in_data = 32'h0000_00a1;
    tick();
    in_valid = '0;
    chk("a1_req", 32'(req), 32'h1);
    gnt = 4'b0001;
    tick();
    gnt = '0;
    beat("a1", 8'ha1, 2'd0);
    chk("a1_req_drop", 32'(req), 32'h0);
    tick();
    chk("a1_idle_ov", 32'(out_valid), 32'h0);
    chk("a1_hold", 32'(out_data), 32'ha1);
    // fill queue 2, then push refused while popped
    for (int k = 0; k < 4; k++) begin
      in_valid = 4'b0100; in_data = 32'(8'h20 + k) << 16;
      tick();
    end
    in_valid = '0;
    chk("q2_full_rdy", 32'(in_ready), 32'hb);
    chk("q2_req", 32'(req), 32'h4);
    in_valid = 4'b0100; in_data = 32'h0099_0000; gnt = 4'b0100;
    tick();
    in_valid = '0;
    beat("q2_p0", 8'h20, 2'd2);
    chk("q2_rdy_back", 32'(in_ready), 32'hf);
    tick(); beat("q2_p1", 8'h21, 2'd2);
    tick(); beat("q2_p2", 8'h22, 2'd2);
    tick(); beat("q2_p3", 8'h23, 2'd2);
    chk("q2_empty_req", 32'(req), 32'h0);
    tick();
    chk("stray_ov", 32'(out_valid), 32'h0);
    chk("stray_err", 32'(err_multi_gnt), 32'h0);
    gnt = '0;
    // queue 1 time-slice hold of three grants over two entries
    in_valid = 4'b0010; in_data = 32'h0000_3100; tick();
    in_data = 32'h0000_3200; tick();
    in_valid = '0;
    gnt = 4'b0010;
    tick(); beat("q1_p0", 8'h31, 2'd1);
    tick(); beat("q1_p1", 8'h32, 2'd1);
    tick();
    gnt = '0;
    chk("q1_third_ov", 32'(out_valid), 32'h0);
    chk("q1_err", 32'(err_multi_gnt), 32'h0);
    chk("q1_hold_id", 32'(out_id), 32'h1);
    // multi-hot grant
    in_valid = 4'b0101; in_data = 32'h002a_000a;
    tick();
    in_valid = '0;
    gnt = 4'b0101;
    tick();
    gnt = '0;
    chk("mh_ov", 32'(out_valid), 32'h0);
    chk("mh_err", 32'(err_multi_gnt), 32'h1);
    chk("mh_req", 32'(req), 32'h5);
    tick();
    chk("mh_sticky", 32'(err_multi_gnt), 32'h1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("mh_clr", 32'(err_multi_gnt), 32'h0);
    err_clr = 1'b1; gnt = 4'b1111; tick(); err_clr = 1'b0; gnt = '0;
    chk("mh_set_wins", 32'(err_multi_gnt), 32'h1);
    chk("mh_rdy", 32'(in_ready), 32'hf);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    gnt = 4'b0001; tick(); beat("mh_q0", 8'h0a, 2'd0);
    gnt = 4'b0100; tick(); beat("mh_q2", 8'h2a, 2'd2);
    gnt = '0;
    chk("mh_drained", 32'(req), 32'h0);
    // queue 3 interleaved push/pop across pointer wrap
    in_valid = 4'b1000; in_data = 32'h6000_0000;
    tick();
    for (int k = 1; k < 6; k++) begin
      in_data = 32'(8'h60 + k) << 24; gnt = 4'b1000;
      tick();
      beat("q3_wrap", 8'(8'h60 + k - 1), 2'd3);
      chk("q3_req", 32'(req), 32'h8);
    end
    in_valid = '0;
    tick();
    gnt = '0;
    beat("q3_last", 8'h65, 2'd3);
    chk("q3_empty", 32'(req), 32'h0);
    // asynchronous reset with queues partially full and output active
    in_valid = 4'b0111; in_data = 32'h0043_2201;
    tick(); tick();
    in_valid = '0;
    gnt = 4'b0001;
    tick();
    gnt = '0;
    chk("pre_rst_ov", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(req), 32'h0);
    chk("ar_rdy", 32'(in_ready), 32'hf);
    chk("ar_ov", 32'(out_valid), 32'h0);
    chk("ar_data", 32'(out_data), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      gnt = 4'(1 << k);
      tick();
      chk("post_rst_ov", 32'(out_valid), 32'h0);
    end
    gnt = '0;
    chk("post_rst_req", 32'(req), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arb_req_frontend.md
ARB_REQ_FRONTEND -- requirements
Module: arb_req_frontend

Interface
REQ-001 Parameter DW, default 8, payload width per requester entry.
REQ-002 Parameter DEPTH, default 4, entries per requester queue; power of two, minimum 2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  4  per-requester push strobe; bit i belongs to requester i.
REQ-006 in_data  input  4*DW  per-requester payload; requester i occupies bits [i*DW +: DW].
REQ-007 in_ready  output  4  per-requester queue-not-full.
REQ-008 req  output  4  request vector driven to the 4-way round-robin arbiter; bit i = queue i non-empty.
REQ-009 gnt  input  4  grant vector returned by the arbiter; one-hot or zero.
REQ-010 out_valid  output  1  one popped entry is presented this cycle.
REQ-011 out_data  output  DW  popped payload.
REQ-012 out_id  output  2  index of the requester whose entry is presented.
REQ-013 err_multi_gnt  output  1  sticky flag: a multi-hot gnt was received.
REQ-014 err_clr  input  1  synchronous clear of err_multi_gnt.

Function
REQ-015 Four independent circular FIFOs, DEPTH x DW each, with wrapping read/write pointers and an occupancy count of width $clog2(DEPTH)+1.
REQ-016 in_ready[i] SHALL be 1 when count[i] < DEPTH, taken from registered count only; no same-cycle pop bypass, so a full queue refuses a push even while being popped.
REQ-017 Push on queue i SHALL occur when in_valid[i] & in_ready[i]; in_valid while not ready is ignored, data not stored.
REQ-018 req[i] SHALL equal (count[i] != 0) from registered state; a push at edge N raises req[i] in the cycle after N.
REQ-019 Pop on queue i SHALL occur when gnt is exactly one-hot at bit i and count[i] != 0.
REQ-020 gnt == 0, or one-hot to an empty queue (stray grant after the arbiter's registered GNT lag): no pop, no error, out_valid 0 next cycle.
REQ-021 Multi-hot gnt: no pop on any queue; err_multi_gnt SHALL set at the next edge and hold until err_clr.
REQ-022 err_clr and a multi-hot gnt in the same cycle: set wins.
REQ-023 Output register: pop at edge T SHALL present out_valid=1, out_data=popped entry, out_id=i from edge T until edge T+1; one entry per cycle maximum.
REQ-024 No pop in a cycle: out_valid SHALL be 0; out_data and out_id hold their last values.
REQ-025 Consecutive grant cycles to the same requester (time-slice hold, up to 3) SHALL pop one entry per cycle in FIFO order until empty; req[i] drops the cycle after the last entry leaves.
REQ-026 Simultaneous push and pop on one queue SHALL both take effect; count unchanged, pointers both advance.
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order with no lost or duplicated entries.
REQ-028 No backpressure on the output; the consumer accepts every out_valid beat.

Reset
REQ-029 While rst_n=0: all counts and pointers 0, req=4'b0000, in_ready=4'b1111, out_valid=0, out_data=0, out_id=0, err_multi_gnt=0.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries immediately; FIFO storage need not be cleared.
REQ-031 First push accepted at the first rising edge after rst_n deasserts.

Verification
REQ-032 Push A1 on req 0, gnt=4'b0000 -> req=4'b0001 one cycle later; then gnt=4'b0001 for 1 cycle -> out_valid=1, out_data=A1, out_id=0 next cycle, req=4'b0000.
REQ-033 Fill queue 2 with 4 entries -> in_ready[2]=0; push+gnt=4'b0100 same cycle -> push refused, one entry popped, in_ready[2]=1 next cycle.
REQ-034 Queue 1 holds 2 entries, gnt=4'b0010 for 3 cycles -> two out_valid beats in order, third cycle out_valid=0, no error.
REQ-035 gnt=4'b0101 with queues 0 and 2 non-empty -> no pop, counts unchanged, err_multi_gnt=1; err_clr pulse -> 0 next cycle.
REQ-036 Push 6 and pop 6 interleaved on queue 3 (pointer wrap) -> outputs match push order exactly.
REQ-037 rst_n low with all queues partially full -> req=0, in_ready=4'b1111, out_valid=0 immediately, no entry emitted after release.
